// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: multi-cycle chunked adder/subtractor with valid/ready handshakes
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);
  localparam logic [1:0] IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CHUNK-1:0] a_k, b_k, s_k;
  logic cy_k;
  always_comb begin
    a_k = a_q[idx_q*CHUNK +: CHUNK];
    b_k = b_q[idx_q*CHUNK +: CHUNK];
    {cy_k, s_k} = {1'b0, a_k} + {1'b0, b_k} + (CHUNK+1)'(carry_q);
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d = ovf_q;
    idx_d = idx_q;
    if (state_q == IDLE && in_valid) begin
      a_d = a;
      b_d = sub ? ~b : b;
      carry_d = sub | c_in;
      sum_d = '0;
      idx_d = '0;
      state_d = ADD;
    end else if (state_q == ADD) begin
      sum_d[idx_q*CHUNK +: CHUNK] = s_k;
      carry_d = cy_k;
      idx_d = idx_q == LAST ? '0 : idx_q + 1'b1;
      if (idx_q == LAST) begin
        c_out_d = cy_k;
        ovf_d = s_k[CHUNK-1] ^ a_k[CHUNK-1] ^ b_k[CHUNK-1] ^ cy_k;
        state_d = DONE;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q <= 1'b0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q <= ovf_d;
      idx_q <= idx_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign sum = sum_q;
  assign c_out = c_out_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb_serial_chunk_adder: scoreboard bench over 16/4, 32/8 and 8/8 instances
module tb_serial_chunk_adder;
  typedef struct {
    logic [31:0] sum;
    logic co;
    logic of;
  } exp_t;
  logic clk, rst;
  logic iv[3], ir[3], ci[3], sb[3], ov[3], orr[3], co[3], of[3];
  logic [15:0] a16, b16, s16;
  logic [31:0] a32, b32, s32;
  logic [7:0] a8, b8, s8;
  exp_t q[$];
  int vec = 0, miss = 0;
  logic keep = 1'b0;
  serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a16), .b(b16),
    .c_in(ci[0]), .sub(sb[0]), .out_valid(ov[0]), .out_ready(orr[0]), .sum(s16),
    .c_out(co[0]), .overflow(of[0]));
  serial_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a32), .b(b32),
    .c_in(ci[1]), .sub(sb[1]), .out_valid(ov[1]), .out_ready(orr[1]), .sum(s32),
    .c_out(co[1]), .overflow(of[1]));
  serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a8), .b(b8),
    .c_in(ci[2]), .sub(sb[2]), .out_valid(ov[2]), .out_ready(orr[2]), .sum(s8),
    .c_out(co[2]), .overflow(of[2]));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  function automatic int wid(int k);
    return k == 0 ? 16 : k == 1 ? 32 : 8;
  endfunction
  function automatic int nch(int k);
    return k == 2 ? 1 : 4;
  endfunction
  function automatic logic [31:0] get_sum(int k);
    return k == 0 ? {16'd0, s16} : k == 1 ? s32 : {24'd0, s8};
  endfunction
  function automatic exp_t model(int w, logic [31:0] av, logic [31:0] bv, logic cin, logic sbv);
    logic [63:0] m, lm, ae, be, full, low;
    logic c;
    exp_t e;
    m = (64'd1 << w) - 1;
    lm = (64'd1 << (w - 1)) - 1;
    ae = {32'd0, av} & m;
    be = (sbv ? ~{32'd0, bv} : {32'd0, bv}) & m;
    c = sbv | cin;
    full = ae + be + 64'(c);
    low = (ae & lm) + (be & lm) + 64'(c);
    e.sum = 32'(full & m);
    e.co = full[w];
    e.of = low[w-1] ^ full[w];
    return e;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic accept(int k, logic [31:0] av, logic [31:0] bv, logic cin, logic sbv);
    chk("in_ready", 32'(ir[k]), 32'd1);
    case (k)
      0: begin a16 = av[15:0]; b16 = bv[15:0]; end
      1: begin a32 = av; b32 = bv; end
      default: begin a8 = av[7:0]; b8 = bv[7:0]; end
    endcase
    ci[k] = cin;
    sb[k] = sbv;
    iv[k] = 1'b1;
    q.push_back(model(wid(k), av, bv, cin, sbv));
    @(negedge clk);
    iv[k] = 1'b0;
  endtask
  task automatic wait_result(int k, int bp);
    int cnt = 0;
    exp_t e;
    while (!ov[k] && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("latency", 32'(cnt), 32'(nch(k)));
    if (q.size() == 0) begin
      chk("queue_empty", 32'd0, 32'd1);
      return;
    end
    e = q.pop_front();
    chk("sum", get_sum(k), e.sum);
    chk("c_out", 32'(co[k]), 32'(e.co));
    chk("overflow", 32'(of[k]), 32'(e.of));
    iv[k] = 1'b0;
    repeat (bp) begin
      @(negedge clk);
      chk("bp_valid", 32'(ov[k]), 32'd1);
      chk("bp_sum", get_sum(k), e.sum);
    end
    orr[k] = 1'b1;
    @(negedge clk);
    orr[k] = keep;
    chk("idle_ready", 32'(ir[k]), 32'd1);
    chk("idle_valid", 32'(ov[k]), 32'd0);
    chk("hold_sum", get_sum(k), e.sum);
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ci[k] = 1'b0; sb[k] = 1'b0; orr[k] = 1'b0;
    end
    a16 = '0; b16 = '0; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", 32'(ir[k]), 32'd1);
      chk("rst_valid", 32'(ov[k]), 32'd0);
      chk("rst_sum", get_sum(k), 32'd0);
      chk("rst_cout", 32'(co[k]), 32'd0);
      chk("rst_ovf", 32'(of[k]), 32'd0);
    end
    accept(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
    wait_result(0, 0);
    accept(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0);
    wait_result(0, 0);
    accept(0, 32'h0005, 32'h0007, 1'b1, 1'b1);
    wait_result(0, 0);
    accept(0, 32'h8000, 32'h0001, 1'b0, 1'b1);
    wait_result(0, 0);
    accept(0, 32'h1234, 32'h1111, 1'b1, 1'b0);
    wait_result(0, 6);
    accept(0, 32'h0001, 32'h0002, 1'b0, 1'b0);
    iv[0] = 1'b1;
    a16 = 16'hFFFF;
    b16 = 16'hFFFF;
    sb[0] = 1'b1;
    wait_result(0, 0);
    accept(0, 32'h00F0, 32'h000F, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(q.pop_back());
    chk("midrst_ready", 32'(ir[0]), 32'd1);
    chk("midrst_valid", 32'(ov[0]), 32'd0);
    chk("midrst_sum", get_sum(0), 32'd0);
    chk("midrst_cout", 32'(co[0]), 32'd0);
    chk("midrst_ovf", 32'(of[0]), 32'd0);
    repeat (6) begin
      @(negedge clk);
      chk("midrst_never_valid", 32'(ov[0]), 32'd0);
    end
    keep = 1'b1;
    for (int k = 1; k < 3; k++) begin
      orr[k] = 1'b1;
      repeat (200) begin
        accept(k, $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
        wait_result(k, 0);
      end
      orr[k] = 1'b0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
